// File: rtl/alu_bist_ctrl.sv
// BIST controller: LFSR operands, alu_sel sweep, 17-bit MISR compaction, golden compare.
// Latency: 4*2^PAT_LOG2 RUN cycles + 1 CMP cycle; results valid at the following edge.
// No backpressure: start is a one-cycle request, ignored while busy.
module alu_bist_ctrl #(
  parameter int          PAT_LOG2   = 8,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_1234,
  parameter logic [16:0] GOLDEN_SIG = 17'h0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] a_out,
  output logic [15:0] b_out,
  output logic [1:0]  alu_sel_out,
  input  logic [15:0] result_in,
  input  logic        cout_in,
  output logic        test_mode,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [16:0] signature
);

  localparam int          CW   = PAT_LOG2 + 2;
  // An all-zero LFSR would lock up, so substitute a non-zero seed.
  localparam logic [31:0] SEED = (LFSR_SEED == 32'h0) ? 32'h0000_0001 : LFSR_SEED;

  typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

  state_t          state, state_nxt;
  logic [31:0]     lfsr;
  logic [16:0]     misr;
  logic [CW-1:0]   cnt;
  logic            load, step, capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == {CW{1'b1}}) state_nxt = CMP;
      end
      CMP: begin
        capture   = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= SEED;
      misr      <= '0;
      cnt       <= '0;
      pass      <= 1'b0;
      signature <= '0;
    end else begin
      if (load) begin
        lfsr <= SEED;
        misr <= '0;
        cnt  <= '0;
        pass <= 1'b0;
      end else if (step) begin
        // Response is captured against the operands driven this same cycle.
        misr <= {misr[15:0], misr[16] ^ misr[13]} ^ {cout_in, result_in};
        lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
        cnt  <= cnt + 1'b1;
      end else if (capture) begin
        signature <= misr;
        pass      <= (misr == GOLDEN_SIG);
      end
    end
  end

  assign a_out       = lfsr[31:16];
  assign b_out       = lfsr[15:0];
  assign alu_sel_out = cnt[CW-1:CW-2];
  assign busy        = (state == RUN) || (state == CMP);
  assign test_mode   = busy;
  assign done        = (state == DONE);

endmodule
